// File: rtl/demo_master_if.sv
// Bus between demo_master and its arbiter/slave: request/grant, command phase, read-data return.
interface demo_master_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              bus_req;
    logic              bus_grant;
    logic              bus_valid;
    logic              bus_ready;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_rvalid;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        output bus_req,
        input  bus_grant,
        output bus_valid,
        input  bus_ready,
        output bus_we,
        output bus_addr,
        output bus_wdata,
        input  bus_rvalid,
        input  bus_rdata
    );

    modport slave (
        input  bus_req,
        output bus_grant,
        input  bus_valid,
        output bus_ready,
        input  bus_we,
        input  bus_addr,
        input  bus_wdata,
        output bus_rvalid,
        output bus_rdata
    );
endinterface

// File: rtl/demo_master.sv
// Single-transfer bus master launched by the operator start key (IDLE/REQ/CMD/RDATA/DONE).
// Optional per-phase wait timeout with sticky err: define DEMO_MASTER_TIMEOUT_EN.
module demo_master #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    demo_master_if.master     bus,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_CMD,
        S_RDATA,
        S_DONE
    } state_t;

    state_t            state;
    logic              start_p0;
    logic              start_p1;
    logic              start_edge;
    logic              mode_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              abort;

    generate
        if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
            $error("demo_master: TIMEOUT must be in 1..65535");
        end
    endgenerate

    // start comes from a key: one register stage, then the previous-value register for edge detect
    assign start_edge = start_p0 & ~start_p1;

`ifdef DEMO_MASTER_TIMEOUT_EN
    logic [15:0] wait_cnt;
    logic        waiting;
    logic        err_q;

    always_comb begin
        waiting = 1'b0;
        case (state)
            S_REQ:   waiting = ~bus.bus_grant;
            S_CMD:   waiting = ~bus.bus_ready;
            S_RDATA: waiting = ~bus.bus_rvalid;
            default: waiting = 1'b0;
        endcase
        abort = waiting && (wait_cnt == 16'(TIMEOUT - 1));
    end

    // Any cycle without a wait ends in a state change, so clearing here restarts the count on entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            wait_cnt <= (waiting && !abort) ? wait_cnt + 16'd1 : '0;
            if (abort)
                err_q <= 1'b1;
            else if (state == S_IDLE && start_edge)
                err_q <= 1'b0;
        end
    end

    assign err = err_q;
`else
    assign abort = 1'b0;
    assign err   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            start_p0      <= 1'b0;
            start_p1      <= 1'b0;
            mode_q        <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            bus.bus_req   <= 1'b0;
            bus.bus_valid <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_wdata <= '0;
            rdata         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            start_p0 <= start;
            start_p1 <= start_p0;
            done     <= 1'b0;
            if (abort) begin
                state         <= S_DONE;
                bus.bus_req   <= 1'b0;
                bus.bus_valid <= 1'b0;
                bus.bus_we    <= 1'b0;
                bus.bus_addr  <= '0;
                bus.bus_wdata <= '0;
                done          <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_edge) begin
                            mode_q      <= mode;
                            addr_q      <= addr;
                            wdata_q     <= wdata;
                            state       <= S_REQ;
                            bus.bus_req <= 1'b1;
                            busy        <= 1'b1;
                        end
                    end
                    S_REQ: begin
                        if (bus.bus_grant) begin
                            state         <= S_CMD;
                            bus.bus_valid <= 1'b1;
                            bus.bus_we    <= mode_q;
                            bus.bus_addr  <= addr_q;
                            bus.bus_wdata <= wdata_q;
                        end
                    end
                    S_CMD: begin
                        // Grant is deliberately not looked at once the command phase has started
                        if (bus.bus_ready) begin
                            bus.bus_valid <= 1'b0;
                            bus.bus_we    <= 1'b0;
                            bus.bus_addr  <= '0;
                            bus.bus_wdata <= '0;
                            if (mode_q) begin
                                state       <= S_DONE;
                                bus.bus_req <= 1'b0;
                                done        <= 1'b1;
                            end else begin
                                state <= S_RDATA;
                            end
                        end
                    end
                    S_RDATA: begin
                        if (bus.bus_rvalid) begin
                            rdata       <= bus.bus_rdata;
                            state       <= S_DONE;
                            bus.bus_req <= 1'b0;
                            done        <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state         <= S_IDLE;
                        bus.bus_req   <= 1'b0;
                        bus.bus_valid <= 1'b0;
                        bus.bus_we    <= 1'b0;
                        bus.bus_addr  <= '0;
                        bus.bus_wdata <= '0;
                        busy          <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/demo_master.md
DEMO_MASTER -- requirements
Module: demo_master

Interface
REQ-001 SHALL have parameter ADDR_W, 16, address width.
REQ-002 SHALL have parameter DATA_W, 8, data width.
REQ-003 SHALL have parameter TIMEOUT, 255, maximum wait cycles per phase; legal range 1..65535.
REQ-004 SHALL have ports:
  clk  in  1  single clock; all state on its rising edge.
  rst  in  1  reset; asynchronous assert, active-high.
  start  in  1  level start request from the operator key.
  mode  in  1  transfer type: 0 read, 1 write.
  addr  in  ADDR_W  transfer address.
  wdata  in  DATA_W  write data.
  bus_req  out  1  bus request to arbiter.
  bus_grant  in  1  arbiter grant.
  bus_valid  out  1  address/command phase valid.
  bus_ready  in  1  slave accepts command.
  bus_we  out  1  write enable.
  bus_addr  out  ADDR_W  bus address.
  bus_wdata  out  DATA_W  bus write data.
  bus_rvalid  in  1  read data valid.
  bus_rdata  in  DATA_W  read data.
  rdata  out  DATA_W  last read result, held.
  busy  out  1  transfer in progress.
  done  out  1  one-cycle completion pulse.
  err  out  1  sticky timeout flag.

Function
REQ-005 SHALL detect the rising edge of start (registered previous value); level-high start SHALL NOT retrigger.
REQ-006 SHALL on a start edge in IDLE capture mode, addr, wdata into internal registers and go to REQ; start edges outside IDLE SHALL be ignored.
REQ-007 SHALL implement states IDLE, REQ, CMD, RDATA, DONE.
REQ-008 REQ: bus_req=1; on bus_grant=1 go to CMD next cycle.
REQ-009 CMD: bus_req=1, bus_valid=1, bus_we/bus_addr/bus_wdata from captured registers, held stable until bus_ready=1 sampled with bus_valid=1; then write -> DONE, read -> RDATA.
REQ-010 RDATA: bus_req=1, bus_valid=0; on bus_rvalid=1 load rdata from bus_rdata, go to DONE.
REQ-011 DONE: done=1 for exactly one cycle, bus_req=0, return to IDLE.
REQ-012 busy SHALL be 1 in REQ, CMD, RDATA, DONE; 0 in IDLE.
REQ-013 bus_valid SHALL be 1 only in CMD; bus_addr/bus_wdata/bus_we SHALL be 0 outside CMD.
REQ-014 bus_rvalid outside RDATA SHALL be ignored; rdata SHALL change only in RDATA.
REQ-015 bus_grant deasserting during CMD or RDATA SHALL be ignored (grant is sampled only in REQ).
REQ-016 Minimum write latency: start edge to done = 4 cycles with grant and ready already high; read adds 1 cycle plus rvalid wait.
REQ-017 A new start edge SHALL clear err when it launches a transfer.

Reset
REQ-018 rst=1 SHALL asynchronously force IDLE, all outputs 0, rdata 0, err 0, captured registers 0, previous-start register 0.
REQ-019 rst asserted mid-transfer SHALL drop bus_req and bus_valid immediately with no done pulse; first start edge after release SHALL begin a fresh transfer.

Configuration
REQ-020 With macro DEMO_MASTER_TIMEOUT_EN defined, a wait counter SHALL reset on each state entry, count cycles in REQ, CMD, RDATA; at TIMEOUT cycles the block SHALL set err=1, drop bus_req/bus_valid, pulse done, and return to IDLE with rdata unchanged.
REQ-021 Without DEMO_MASTER_TIMEOUT_EN, no counter SHALL exist, waits SHALL be unbounded, err SHALL be tied 0.

Verification
REQ-022 Write: mode=1, addr=0x1230, wdata=0xA5, grant and ready high -> one CMD cycle with bus_we=1, bus_addr=0x1230, bus_wdata=0xA5; done 4 cycles after edge.
REQ-023 Read: mode=0, addr=0x00F0, rvalid 3 cycles after CMD accepted with rdata=0x3C -> rdata=0x3C, single done pulse, busy low next cycle.
REQ-024 Backpressure: ready held low 10 cycles -> bus_valid, bus_addr stable all 10 cycles; start re-pressed meanwhile -> no second transfer.
REQ-025 Timeout (macro on, TIMEOUT=8): grant never asserted -> err=1 and done 8 cycles after REQ entry; next start edge clears err.
REQ-026 Reset mid-RDATA -> bus_req=0 same cycle, no done, rdata=0; next start edge completes normally.
